// File: rtl/seg_divider_pkg.sv
// Shared types and constants for the 7-segment restoring divider.
// Holds the FSM state encoding, legal digit codes and the dividend helper.
package seg_div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_DIVIDE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Active-high segment order {a,b,c,d,e,f,g}
  localparam logic [6:0] SEG_0 = 7'h7E;
  localparam logic [6:0] SEG_1 = 7'h30;
  localparam logic [6:0] SEG_2 = 7'h6D;
  localparam logic [6:0] SEG_3 = 7'h79;
  localparam logic [6:0] SEG_4 = 7'h33;
  localparam logic [6:0] SEG_5 = 7'h5B;
  localparam logic [6:0] SEG_6 = 7'h5F;
  localparam logic [6:0] SEG_7 = 7'h70;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h7B;

  localparam int         DIV_STEPS = 10;
  localparam logic [3:0] Q_MAX     = 4'd15;

  function automatic logic [9:0] bcd3_to_bin(input logic [3:0] h,
                                             input logic [3:0] t,
                                             input logic [3:0] o);
    return 10'(h) * 10'd100 + 10'(t) * 10'd10 + 10'(o);
  endfunction

endpackage

// File: rtl/seg_divider_if.sv
// Request/result bundle of the divider. Handshake: start is sampled only
// while busy is low; done is a one-cycle pulse and results hold until next start.
interface seg_div_if;
  logic       start;
  logic [6:0] h_seg;
  logic [6:0] t_seg;
  logic [6:0] o_seg;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [3:0] a;
  logic [3:0] rem;
  logic       err_seg;
  logic       err_div0;
  logic       err_ovf;

  modport master (
    output start, h_seg, t_seg, o_seg, b,
    input  busy, done, a, rem, err_seg, err_div0, err_ovf
  );

  modport slave (
    input  start, h_seg, t_seg, o_seg, b,
    output busy, done, a, rem, err_seg, err_div0, err_ovf
  );
endinterface

// File: rtl/seg_divider_seg7_to_bcd.sv
// Combinational 7-segment to BCD decoder with an illegal-code flag.
// SEG_INV=1 treats the incoming segments as active-low.
module seg7_to_bcd
  import seg_div_pkg::*;
#(
  parameter bit SEG_INV = 1'b0
) (
  input  logic [6:0] seg,
  output logic [3:0] digit,
  output logic       invalid
);

  logic [6:0] code;

  always_comb begin
    code    = SEG_INV ? ~seg : seg;
    digit   = 4'd0;
    invalid = 1'b0;
    case (code)
      SEG_0:   digit = 4'd0;
      SEG_1:   digit = 4'd1;
      SEG_2:   digit = 4'd2;
      SEG_3:   digit = 4'd3;
      SEG_4:   digit = 4'd4;
      SEG_5:   digit = 4'd5;
      SEG_6:   digit = 4'd6;
      SEG_7:   digit = 4'd7;
      SEG_8:   digit = 4'd8;
      SEG_9:   digit = 4'd9;
      default: invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_divider.sv
// Sequential restoring divider: recovers a = N / b and rem = N % b where N
// is a three-digit 7-segment product. One quotient bit per cycle, MSB first.
module seg_divider
  import seg_div_pkg::*;
#(
  parameter bit SEG_INV = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  seg_div_if.slave   bus,
  output state_e     dbg_state
);

  state_e     state_q, state_d;
  logic [6:0] hseg_q, hseg_d, tseg_q, tseg_d, oseg_q, oseg_d;
  logic [3:0] b_q, b_d;
  logic [9:0] dvd_q, dvd_d;
  logic [8:0] quo_q, quo_d;
  logic [3:0] pr_q, pr_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] a_q, a_d, rem_q, rem_d;
  logic       es_q, es_d, ed_q, ed_d, eo_q, eo_d;

  logic [3:0] h_dig, t_dig, o_dig;
  logic       h_bad, t_bad, o_bad;

  seg7_to_bcd #(.SEG_INV(SEG_INV)) u_dec_h (.seg(hseg_q), .digit(h_dig), .invalid(h_bad));
  seg7_to_bcd #(.SEG_INV(SEG_INV)) u_dec_t (.seg(tseg_q), .digit(t_dig), .invalid(t_bad));
  seg7_to_bcd #(.SEG_INV(SEG_INV)) u_dec_o (.seg(oseg_q), .digit(o_dig), .invalid(o_bad));

  // Restoring step: remainder stays below b (<=15), so 4 bits hold it
  // between steps and the shifted trial value needs 5.
  logic [4:0] pr_shift;
  logic [5:0] diff;
  logic       ge;
  logic [3:0] pr_next;
  logic [9:0] quo_next;
  logic       seg_bad;
  logic       div0;

  always_comb begin
    pr_shift = {pr_q, dvd_q[9]};
    diff     = {1'b0, pr_shift} - {2'b00, b_q};
    ge       = ~diff[5];
    pr_next  = ge ? diff[3:0] : pr_shift[3:0];
    quo_next = {quo_q, ge};
    seg_bad  = h_bad | t_bad | o_bad;
    div0     = (b_q == 4'd0);
  end

  always_comb begin
    state_d = state_q;
    hseg_d  = hseg_q;
    tseg_d  = tseg_q;
    oseg_d  = oseg_q;
    b_d     = b_q;
    dvd_d   = dvd_q;
    quo_d   = quo_q;
    pr_d    = pr_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    rem_d   = rem_q;
    es_d    = es_q;
    ed_d    = ed_q;
    eo_d    = eo_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          hseg_d  = bus.h_seg;
          tseg_d  = bus.t_seg;
          oseg_d  = bus.o_seg;
          b_d     = bus.b;
          a_d     = 4'd0;
          rem_d   = 4'd0;
          es_d    = 1'b0;
          ed_d    = 1'b0;
          eo_d    = 1'b0;
          state_d = ST_DECODE;
        end
      end

      ST_DECODE: begin
        es_d = seg_bad;
        ed_d = div0;
        if (seg_bad || div0) begin
          state_d = ST_DONE;
        end else begin
          dvd_d   = bcd3_to_bin(h_dig, t_dig, o_dig);
          pr_d    = 4'd0;
          quo_d   = 9'd0;
          cnt_d   = 4'd0;
          state_d = ST_DIVIDE;
        end
      end

      ST_DIVIDE: begin
        dvd_d = {dvd_q[8:0], 1'b0};
        pr_d  = pr_next;
        quo_d = quo_next[8:0];
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(DIV_STEPS - 1)) begin
          state_d = ST_DONE;
          rem_d   = pr_next;
          if (quo_next > 10'(Q_MAX)) begin
            eo_d = 1'b1;
            a_d  = Q_MAX;
          end else begin
            a_d  = quo_next[3:0];
          end
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      hseg_q  <= 7'd0;
      tseg_q  <= 7'd0;
      oseg_q  <= 7'd0;
      b_q     <= 4'd0;
      dvd_q   <= 10'd0;
      quo_q   <= 9'd0;
      pr_q    <= 4'd0;
      cnt_q   <= 4'd0;
      a_q     <= 4'd0;
      rem_q   <= 4'd0;
      es_q    <= 1'b0;
      ed_q    <= 1'b0;
      eo_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hseg_q  <= hseg_d;
      tseg_q  <= tseg_d;
      oseg_q  <= oseg_d;
      b_q     <= b_d;
      dvd_q   <= dvd_d;
      quo_q   <= quo_d;
      pr_q    <= pr_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      rem_q   <= rem_d;
      es_q    <= es_d;
      ed_q    <= ed_d;
      eo_q    <= eo_d;
    end
  end

  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.done     = (state_q == ST_DONE);
  assign bus.a        = a_q;
  assign bus.rem      = rem_q;
  assign bus.err_seg  = es_q;
  assign bus.err_div0 = ed_q;
  assign bus.err_ovf  = eo_q;
  assign dbg_state    = state_q;

endmodule
